ctrl_unit_seq: RTL and testbench
================================

Name: ctrl_unit_seq

Overview:
- Parametrised successor of the current 6-state control FSM: fetches instruction words through a valid/ready handshake, decodes them, and sequences the PC, register-bank and ALU controls.
- Adds conditional jumps evaluated against ALU flags, extension-word fetch for indexed, symbolic, absolute and immediate modes, write-back suppression for CMP/BIT, illegal-opcode reporting and a fetch watchdog.
- Sits between instruction memory/PC logic and bank_register/ALU in the datapath.

Parameters:
- IW, 16, instruction word width; the opcode fields below assume 16.
- RAW, 4, register address width (src_reg/dst_reg/wr_reg).
- OPW, 5, ALU op_code width.
- OFFW, 10, jump offset width, taken from instr[OFFW-1:0].
- TIMEOUT, 255, cycles waiting in FETCH/EXT before fetch_timeout is raised; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  reset (see Behaviour)
- instr_valid  in  1  instruction/extension word available
- instr_data  in  IW  instruction/extension word
- flag_z, flag_c, flag_n, flag_v  in  1 each  ALU status flags
- instr_ready  out  1  block accepts a word this cycle
- pc_inc  out  1  1-cycle pulse: load PC+2
- en_pc_2  out  1  select +2 path in PC mux
- branch_en  out  1  1-cycle pulse: select PC+2*sext(offset)
- pc_offset  out  OFFW  raw jump offset
- src_reg, dst_reg, wr_reg  out  RAW  register-bank addresses
- wr_en  out  1  register-bank write strobe
- op_code  out  OPW  ALU select
- byte_op  out  1  instr[6], B/W bit
- ext_word  out  IW  last fetched extension word
- ext_sel  out  1  0 = source extension, 1 = destination extension
- illegal  out  1  1-cycle pulse on an unsupported opcode
- fetch_timeout  out  1  sticky until the next handshake or reset
- fsm_state  out  3  encoded current state

Behaviour:
- Reset: one clock; rst is asynchronous and active-high.
  - rst forces state FETCH, clears the latched instruction, ext count and watchdog.
  - All outputs are 0 while rst is high, including instr_ready.
  - A reset mid-instruction abandons it with no wr_en and no pc_inc.
- State encoding: FETCH=0, DECODE=1, EXT=2, EXEC=3, WB=4. Transitions occur only on the clk rising edge.
- FETCH:
  - instr_ready=1, en_pc_2=1.
  - On instr_valid&&instr_ready: latch instr_data, pulse pc_inc the next cycle, go DECODE.
  - Otherwise hold state.
- DECODE:
  - instr[15:12]=0 or 1 (single-op not yet supported): pulse illegal, go FETCH.
  - instr[15:13]=001 is a jump; cond=instr[12:10]:
    - 000 JNE Z=0; 001 JEQ Z=1; 010 JNC C=0; 011 JC C=1
    - 100 JN N=1; 101 JGE N^V=0; 110 JL N^V=1; 111 JMP always
  - Flags are sampled in DECODE.
  - Taken jump: go EXEC. Not taken: go FETCH.
  - Double-op (4..F): op_code = opcode-4 (MOV=0 ... AND=11), src_reg=instr[11:8], dst_reg=instr[3:0].
  - Extension words needed (0-2):
    - one source extension when As=instr[5:4] is 01, or As=11 with src_reg=0 (immediate);
    - one destination extension when Ad=instr[7]=1.
  - Needed>0: go EXT. Else go EXEC.
- EXT:
  - instr_ready=1; on each handshake capture ext_word and pulse pc_inc.
  - Source word first (ext_sel=0), then destination word (ext_sel=1).
  - A 2-bit counter tracks words remaining; when it reaches 0, go EXEC.
- EXEC:
  - Taken jump: branch_en=1 and pc_offset=instr[9:0] for exactly this cycle, then go FETCH; no WB.
  - Double-op: hold op_code/src_reg/dst_reg stable for one cycle, go WB.
- WB:
  - wr_reg=dst_reg.
  - wr_en=1 for one cycle except CMP (op 5) and BIT (op 7), which keep wr_en=0.
  - Go FETCH.
- Latency:
  - Register-mode double-op: 4 cycles, handshake to next instr_ready.
  - Taken jump: 3 cycles. Not-taken jump: 2 cycles.
  - Each extension word adds at least 1 cycle plus memory wait.
- Watchdog:
  - Counts consecutive cycles with instr_ready=1 and no handshake.
  - At TIMEOUT, sets fetch_timeout. The FSM keeps waiting.
  - The count clears on a handshake.
- Outputs: decoded from the state register and latched fields only, with no combinational path from instr_data to outputs. The single exception is instr_ready, which is a function of state and rst.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings;
  - ALU op_code constants MOV..AND;
  - jump condition codes;
  - addressing-mode constants;
  - function needs_ext(As, Ad, src).
- Sub-module jump_cond_eval: combinational; inputs cond[2:0] and the four flags; output take.

Test Plan:
- Reset, then word 0x5405 (ADD R4,R5) with instr_valid held → pc_inc 1 cycle after handshake; op_code=1, src_reg=4, dst_reg=5 in EXEC; wr_en=1, wr_reg=5 in WB; instr_ready re-asserts 4 cycles after the first handshake.
- 0x2405 (JEQ) with flag_z=1 → branch_en one cycle, pc_offset=0x005, no wr_en. Same word with flag_z=0 → no branch_en, back in FETCH after DECODE.
- 0x4035 (MOV #imm,R5) then extension 0x1234 delivered 3 cycles late → FSM waits in EXT, ext_word=0x1234, ext_sel=0, two pc_inc pulses total, then wr_en to R5.
- 0x4495 (MOV 2(R4),4(R5)) → two extension handshakes, ext_sel 0 then 1. 0x9405 (CMP) → wr_en stays 0 in WB.
- 0x1000 → illegal pulse one cycle, return to FETCH. With TIMEOUT=4 and instr_valid=0 → fetch_timeout rises after 4 cycles, clears on the next handshake.
- Assert rst in WB of an ADD → wr_en never pulses, all outputs 0 immediately, fsm_state=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control sequencer.
//   - FSM state encodings (visible on fsm_state)
//   - ALU op_code values for the double-operand group (MOV..AND)
//   - jump condition codes taken from instr[12:10]
//   - source/destination addressing-mode codes
//   - needs_ext(): number of extension words a double-operand word requires
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXT    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // ALU select = instruction opcode (4..F) minus 4
  localparam int OP_MOV  = 0;
  localparam int OP_ADD  = 1;
  localparam int OP_ADDC = 2;
  localparam int OP_SUBC = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_CMP  = 5;
  localparam int OP_DADD = 6;
  localparam int OP_BIT  = 7;
  localparam int OP_BIC  = 8;
  localparam int OP_BIS  = 9;
  localparam int OP_XOR  = 10;
  localparam int OP_AND  = 11;

  localparam logic [2:0] JC_JNE = 3'd0;
  localparam logic [2:0] JC_JEQ = 3'd1;
  localparam logic [2:0] JC_JNC = 3'd2;
  localparam logic [2:0] JC_JC  = 3'd3;
  localparam logic [2:0] JC_JN  = 3'd4;
  localparam logic [2:0] JC_JGE = 3'd5;
  localparam logic [2:0] JC_JL  = 3'd6;
  localparam logic [2:0] JC_JMP = 3'd7;

  localparam logic [1:0] AS_REG = 2'b00;  // Rn
  localparam logic [1:0] AS_IDX = 2'b01;  // x(Rn), symbolic, absolute
  localparam logic [1:0] AS_IND = 2'b10;  // @Rn
  localparam logic [1:0] AS_INC = 2'b11;  // @Rn+, #imm when Rn = PC
  localparam logic       AD_REG = 1'b0;
  localparam logic       AD_IDX = 1'b1;

  // Source word for indexed modes or immediate (@PC+), destination word
  // for any indexed destination.
  function automatic logic [1:0] needs_ext(input logic [1:0] as_m,
                                           input logic       ad_m,
                                           input logic [3:0] src);
    logic s_need;
    s_need = (as_m == AS_IDX) || ((as_m == AS_INC) && (src == 4'd0));
    return {1'b0, s_need} + {1'b0, (ad_m == AD_IDX)};
  endfunction

endpackage

// File: rtl/jump_cond_eval.sv
// jump_cond_eval: combinational evaluation of a conditional jump.
//   cond    in  3  condition code instr[12:10]
//   flag_*  in  1  ALU status flags Z, C, N, V
//   take    out 1  jump is taken
module jump_cond_eval
  import ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       flag_n,
  input  logic       flag_v,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (cond)
      JC_JNE:  take = !flag_z;
      JC_JEQ:  take = flag_z;
      JC_JNC:  take = !flag_c;
      JC_JC:   take = flag_c;
      JC_JN:   take = flag_n;
      JC_JGE:  take = !(flag_n ^ flag_v);
      JC_JL:   take = flag_n ^ flag_v;
      JC_JMP:  take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_seq.sv
// ctrl_unit_seq: instruction fetch/decode/sequence controller.
// Fetches instruction and extension words over a valid/ready handshake,
// decodes double-operand ops and conditional jumps, and drives PC,
// register-bank and ALU controls.
//   clk, rst           clock, asynchronous active-high reset
//   instr_valid/_data  incoming instruction or extension word
//   flag_z/c/n/v       ALU flags, sampled while decoding a jump
//   instr_ready        word accepted this cycle (FETCH / EXT)
//   pc_inc, en_pc_2    PC+2 load pulse / +2 mux select
//   branch_en, pc_offset  taken-jump pulse and raw offset
//   src_reg, dst_reg, wr_reg, wr_en  register-bank controls
//   op_code, byte_op   ALU select and byte/word bit
//   ext_word, ext_sel  last extension word, 0 = source / 1 = destination
//   illegal            unsupported opcode pulse
//   fetch_timeout      watchdog flag, sticky until next handshake
//   fsm_state          current state encoding
module ctrl_unit_seq
  import ctrl_pkg::*;
#(
  parameter int IW      = 16,
  parameter int RAW     = 4,
  parameter int OPW     = 5,
  parameter int OFFW    = 10,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [IW-1:0]   instr_data,
  input  logic            flag_z,
  input  logic            flag_c,
  input  logic            flag_n,
  input  logic            flag_v,
  output logic            instr_ready,
  output logic            pc_inc,
  output logic            en_pc_2,
  output logic            branch_en,
  output logic [OFFW-1:0] pc_offset,
  output logic [RAW-1:0]  src_reg,
  output logic [RAW-1:0]  dst_reg,
  output logic [RAW-1:0]  wr_reg,
  output logic            wr_en,
  output logic [OPW-1:0]  op_code,
  output logic            byte_op,
  output logic [IW-1:0]   ext_word,
  output logic            ext_sel,
  output logic            illegal,
  output logic            fetch_timeout,
  output logic [2:0]      fsm_state
);

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT);

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_instr;
  logic [IW-1:0]   r_ext_word;
  logic [1:0]      r_ext_cnt;
  logic            r_ext_sel;
  logic            r_pc_inc;
  logic [WDW-1:0]  r_wd_cnt;
  logic            r_timeout;

  logic            w_ready;
  logic            w_hs;
  logic            w_take;
  logic            w_is_single;
  logic            w_is_jump;
  logic            w_is_dbl;
  logic            w_no_wb;
  logic [1:0]      w_need;
  logic [OPW-1:0]  w_op;
  logic [WDW-1:0]  w_wd_inc;

  assign w_ready     = !rst && ((r_state == ST_FETCH) || (r_state == ST_EXT));
  assign w_hs        = w_ready && instr_valid;

  // Decode works purely from the latched word, never from instr_data
  assign w_is_single = (r_instr[15:13] == 3'b000);
  assign w_is_jump   = (r_instr[15:13] == 3'b001);
  assign w_is_dbl    = (r_instr[15:14] != 2'b00);
  assign w_op        = OPW'(r_instr[15:12] - 4'd4);
  assign w_need      = needs_ext(r_instr[5:4], r_instr[7], r_instr[11:8]);
  assign w_no_wb     = (w_op == OPW'(OP_CMP)) || (w_op == OPW'(OP_BIT));
  assign w_wd_inc    = r_wd_cnt + 1'b1;

  jump_cond_eval u_jump_cond (
    .cond   (r_instr[12:10]),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .flag_n (flag_n),
    .flag_v (flag_v),
    .take   (w_take)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  if (w_hs) w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_is_single)    w_next = ST_FETCH;
        else if (w_is_jump) w_next = w_take ? ST_EXEC : ST_FETCH;
        else                w_next = (w_need != 2'd0) ? ST_EXT : ST_EXEC;
      end
      // Leave on the handshake that consumes the last outstanding word
      ST_EXT:    if (w_hs && (r_ext_cnt == 2'd1)) w_next = ST_EXEC;
      ST_EXEC:   w_next = w_is_jump ? ST_FETCH : ST_WB;
      ST_WB:     w_next = ST_FETCH;
      default:   w_next = ST_FETCH;
    endcase
  end

  // Latched instruction, extension words, PC pulse and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= '0;
      r_ext_word <= '0;
      r_ext_cnt  <= 2'd0;
      r_ext_sel  <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_wd_cnt   <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_pc_inc <= w_hs;
      if ((r_state == ST_FETCH) && w_hs) r_instr <= instr_data;
      if (r_state == ST_DECODE) r_ext_cnt <= w_need;
      if ((r_state == ST_EXT) && w_hs) begin
        r_ext_word <= instr_data;
        // Source word always comes first, so only the final word of an
        // indexed-destination instruction is a destination word.
        r_ext_sel  <= (r_ext_cnt == 2'd1) && r_instr[7];
        r_ext_cnt  <= r_ext_cnt - 2'd1;
      end
      if (w_hs) begin
        r_wd_cnt  <= '0;
        r_timeout <= 1'b0;
      end else if (w_ready && (TIMEOUT != 0)) begin
        if (r_wd_cnt != WD_LIM) r_wd_cnt <= w_wd_inc;
        if (w_wd_inc == WD_LIM) r_timeout <= 1'b1;
      end
    end
  end

  // Output decode
  always_comb begin
    instr_ready = w_ready;
    en_pc_2     = 1'b0;
    branch_en   = 1'b0;
    pc_offset   = '0;
    wr_en       = 1'b0;
    wr_reg      = '0;
    illegal     = 1'b0;
    case (r_state)
      ST_FETCH:  en_pc_2 = !rst;
      ST_DECODE: illegal = w_is_single;
      // Only taken jumps reach EXEC
      ST_EXEC: if (w_is_jump) begin
        branch_en = 1'b1;
        pc_offset = r_instr[OFFW-1:0];
      end
      ST_WB: begin
        wr_reg = RAW'(r_instr[3:0]);
        wr_en  = !w_no_wb;
      end
      default: ;
    endcase
  end

  assign pc_inc        = r_pc_inc;
  assign op_code       = w_is_dbl ? w_op : '0;
  assign src_reg       = w_is_dbl ? RAW'(r_instr[11:8]) : '0;
  assign dst_reg       = w_is_dbl ? RAW'(r_instr[3:0]) : '0;
  assign byte_op       = w_is_dbl && r_instr[6];
  assign ext_word      = r_ext_word;
  assign ext_sel       = r_ext_sel;
  assign fetch_timeout = r_timeout;
  assign fsm_state     = r_state;

endmodule

// File: tb/tb_ctrl_unit_seq.sv
module tb_ctrl_unit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = '0;
  logic        flag_z = 1'b0, flag_c = 1'b0, flag_n = 1'b0, flag_v = 1'b0;
  logic        instr_ready, pc_inc, en_pc_2, branch_en, wr_en, byte_op;
  logic        ext_sel, illegal, fetch_timeout;
  logic [9:0]  pc_offset;
  logic [3:0]  src_reg, dst_reg, wr_reg;
  logic [4:0]  op_code;
  logic [15:0] ext_word;
  logic [2:0]  fsm_state;
  logic [54:0] all_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_unit_seq #(.IW(16), .RAW(4), .OPW(5), .OFFW(10), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_data(instr_data),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
    .instr_ready(instr_ready), .pc_inc(pc_inc), .en_pc_2(en_pc_2),
    .branch_en(branch_en), .pc_offset(pc_offset), .src_reg(src_reg),
    .dst_reg(dst_reg), .wr_reg(wr_reg), .wr_en(wr_en), .op_code(op_code),
    .byte_op(byte_op), .ext_word(ext_word), .ext_sel(ext_sel),
    .illegal(illegal), .fetch_timeout(fetch_timeout), .fsm_state(fsm_state)
  );

  assign all_out = {instr_ready, pc_inc, en_pc_2, branch_en, pc_offset, src_reg,
                    dst_reg, wr_reg, wr_en, op_code, byte_op, ext_word, ext_sel,
                    illegal, fetch_timeout, fsm_state};

  // Expected behaviour of one instruction, derived from the ISA rules
  typedef struct {
    int lat; int pcinc; int wr; int br; int ill; int next; int extc;
    int op; int src; int dst; int bop; int off; int sel0; int sel1;
  } exp_t;

  function automatic exp_t model(input logic [15:0] w, input logic z, input logic c,
                                 input logic n, input logic v, input int lat);
    exp_t e;
    int hi;
    bit t, sneed, dneed;
    e = '{default: 0};
    hi = int'(w[15:12]);
    e.pcinc = 1;
    if (hi < 2) begin
      e.ill = 1; e.lat = 2;
    end else if (hi < 4) begin
      case (w[12:10])
        3'd0: t = !z;      3'd1: t = z;
        3'd2: t = !c;      3'd3: t = c;
        3'd4: t = n;       3'd5: t = (n == v);
        3'd6: t = (n != v);
        default: t = 1'b1;
      endcase
      e.br  = t ? 1 : 0;
      e.lat = t ? 3 : 2;
      e.off = t ? int'(w[9:0]) : 0;
    end else begin
      e.op  = hi - 4;
      e.src = int'(w[11:8]);
      e.dst = int'(w[3:0]);
      e.bop = int'(w[6]);
      sneed = (w[5:4] == 2'b01) || (w[5:4] == 2'b11 && w[11:8] == 4'd0);
      dneed = w[7];
      e.next  = int'(sneed) + int'(dneed);
      e.extc  = e.next * (1 + lat);
      e.lat   = 4 + e.extc;
      e.pcinc = 1 + e.next;
      e.wr    = (e.op != 5 && e.op != 7) ? 1 : 0;
      e.sel0  = sneed ? 0 : 1;
      e.sel1  = 1;
    end
    return e;
  endfunction

  // Observations of the last run_instr
  int o_lat, o_pcinc, o_wr, o_br, o_ill, o_nhs, o_extc;
  int o_op, o_src, o_dst, o_bop, o_off, o_wreg, o_enpc;
  logic [15:0] ext_w[2];
  logic        ext_s[2];

  task automatic apply_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues word w from FETCH (called at a negedge), serves extension words
  // e0/e1 each 'lat' cycles after EXT requests them, and records outputs
  // until the FSM is back in FETCH.
  task automatic run_instr(input logic [15:0] w, input logic [15:0] e0,
                           input logic [15:0] e1, input int lat);
    int wcnt, idx;
    bit pend;
    o_lat = -1; o_pcinc = 0; o_wr = 0; o_br = 0; o_ill = 0; o_nhs = 0; o_extc = 0;
    o_op = -1; o_src = -1; o_dst = -1; o_bop = -1; o_off = 0; o_wreg = -1; o_enpc = 0;
    ext_w[0] = 'x; ext_w[1] = 'x; ext_s[0] = 1'bx; ext_s[1] = 1'bx;
    instr_data = w;
    instr_valid = 1'b1;
    pend = 1; wcnt = 0; idx = 0;
    for (int k = 1; k <= 60 && o_lat < 0; k++) begin
      @(negedge clk);
      if (pend) begin
        instr_valid = 1'b0;
        pend = 0;
        if (k > 1 && idx < 2) begin
          ext_w[idx] = ext_word; ext_s[idx] = ext_sel; idx++; o_nhs = idx;
        end
      end
      if (pc_inc) o_pcinc++;
      if (wr_en) o_wr++;
      if (branch_en) begin o_br++; o_off = int'(pc_offset); end
      if (illegal) o_ill++;
      if (fsm_state == 3'd2) o_extc++;
      if (fsm_state == 3'd3) begin
        o_op = int'(op_code); o_src = int'(src_reg); o_dst = int'(dst_reg); o_bop = int'(byte_op);
      end
      if (fsm_state == 3'd4) o_wreg = int'(wr_reg);
      if (instr_ready && fsm_state == 3'd0) begin
        o_lat = k; o_enpc = int'(en_pc_2);
      end else if (instr_ready && fsm_state == 3'd2) begin
        if (wcnt == lat) begin
          instr_valid = 1'b1;
          instr_data = (idx == 0) ? e0 : e1;
          pend = 1; wcnt = 0;
        end else wcnt++;
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    rst = 1'b0;
    #1;
    checks++; if (fsm_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    checks++; if (en_pc_2 !== 1'b1) begin failures++; $display("FAIL reset_en_pc_2 got=%b exp=1", en_pc_2); end
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    apply_reset();
    repeat (3) @(negedge clk);
    checks++; if (fetch_timeout !== 1'b0) begin failures++; $display("FAIL wd_early got=%b exp=0", fetch_timeout); end
    @(negedge clk);
    checks++; if (fetch_timeout !== 1'b1) begin failures++; $display("FAIL wd_rise got=%b exp=1", fetch_timeout); end
    repeat (3) @(negedge clk);
    checks++; if (fetch_timeout !== 1'b1 || fsm_state !== 3'd0) begin failures++; $display("FAIL wd_sticky got=%b state=%0d exp=1 state=0", fetch_timeout, fsm_state); end
    run_instr(16'h5405, 16'h0, 16'h0, 0);
    checks++; if (fetch_timeout !== 1'b0) begin failures++; $display("FAIL wd_clear got=%b exp=0", fetch_timeout); end
  endtask

  task automatic test_add();
    run_instr(16'h5405, 16'h0, 16'h0, 0);
    checks++; if (o_lat !== 4) begin failures++; $display("FAIL add_latency got=%0d exp=4", o_lat); end
    checks++; if (o_pcinc !== 1) begin failures++; $display("FAIL add_pc_inc got=%0d exp=1", o_pcinc); end
    checks++; if (o_op !== 1 || o_src !== 4 || o_dst !== 5) begin failures++; $display("FAIL add_fields got=%0d/%0d/%0d exp=1/4/5", o_op, o_src, o_dst); end
    checks++; if (o_wr !== 1 || o_wreg !== 5) begin failures++; $display("FAIL add_wb got=%0d/%0d exp=1/5", o_wr, o_wreg); end
    checks++; if (o_enpc !== 1) begin failures++; $display("FAIL add_en_pc_2 got=%0d exp=1", o_enpc); end
  endtask

  task automatic test_jump();
    flag_z = 1'b1;
    run_instr(16'h2405, 16'h0, 16'h0, 0);
    checks++; if (o_br !== 1 || o_off !== 5) begin failures++; $display("FAIL jeq_taken got=%0d/%0d exp=1/5", o_br, o_off); end
    checks++; if (o_wr !== 0 || o_lat !== 3) begin failures++; $display("FAIL jeq_taken_seq got=wr%0d lat%0d exp=wr0 lat3", o_wr, o_lat); end
    flag_z = 1'b0;
    run_instr(16'h2405, 16'h0, 16'h0, 0);
    checks++; if (o_br !== 0 || o_lat !== 2) begin failures++; $display("FAIL jeq_not_taken got=br%0d lat%0d exp=br0 lat2", o_br, o_lat); end
  endtask

  task automatic test_ext_imm();
    run_instr(16'h4035, 16'h1234, 16'h0, 3);
    checks++; if (o_extc !== 4) begin failures++; $display("FAIL imm_ext_wait got=%0d exp=4", o_extc); end
    checks++; if (o_nhs !== 1 || ext_w[0] !== 16'h1234 || ext_s[0] !== 1'b0) begin failures++; $display("FAIL imm_ext_word got=%0d %h %b exp=1 1234 0", o_nhs, ext_w[0], ext_s[0]); end
    checks++; if (o_pcinc !== 2) begin failures++; $display("FAIL imm_pc_inc got=%0d exp=2", o_pcinc); end
    checks++; if (o_wr !== 1 || o_wreg !== 5 || o_op !== 0) begin failures++; $display("FAIL imm_wb got=%0d/%0d/%0d exp=1/5/0", o_wr, o_wreg, o_op); end
  endtask

  task automatic test_ext_two();
    run_instr(16'h4495, 16'h0002, 16'h0004, 1);
    checks++; if (o_nhs !== 2) begin failures++; $display("FAIL two_ext_count got=%0d exp=2", o_nhs); end
    checks++; if (ext_w[0] !== 16'h0002 || ext_s[0] !== 1'b0) begin failures++; $display("FAIL two_ext_src got=%h %b exp=0002 0", ext_w[0], ext_s[0]); end
    checks++; if (ext_w[1] !== 16'h0004 || ext_s[1] !== 1'b1) begin failures++; $display("FAIL two_ext_dst got=%h %b exp=0004 1", ext_w[1], ext_s[1]); end
    checks++; if (o_pcinc !== 3 || o_lat !== 8) begin failures++; $display("FAIL two_ext_seq got=pc%0d lat%0d exp=pc3 lat8", o_pcinc, o_lat); end
  endtask

  task automatic test_cmp();
    run_instr(16'h9405, 16'h0, 16'h0, 0);
    checks++; if (o_wr !== 0 || o_op !== 5) begin failures++; $display("FAIL cmp_no_wb got=wr%0d op%0d exp=wr0 op5", o_wr, o_op); end
    checks++; if (o_lat !== 4) begin failures++; $display("FAIL cmp_latency got=%0d exp=4", o_lat); end
  endtask

  task automatic test_illegal();
    run_instr(16'h1000, 16'h0, 16'h0, 0);
    checks++; if (o_ill !== 1 || o_lat !== 2 || o_wr !== 0) begin failures++; $display("FAIL illegal got=ill%0d lat%0d wr%0d exp=ill1 lat2 wr0", o_ill, o_lat, o_wr); end
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    run_instr(16'h4035, 16'hBEEF, 16'h0, 0);
    instr_data = 16'h5405; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    checks++; if (fsm_state !== 3'd4) begin failures++; $display("FAIL mid_in_wb got=%0d exp=4", fsm_state); end
    rst = 1'b1; #1;
    checks++; if (all_out !== '0) begin failures++; $display("FAIL mid_reset_outputs got=%h exp=0", all_out); end
    wr_seen = 0;
    repeat (2) begin @(negedge clk); if (wr_en || pc_inc) wr_seen++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (wr_en || pc_inc) wr_seen++; end
    checks++; if (wr_seen !== 0 || fsm_state !== 3'd0) begin failures++; $display("FAIL mid_abandon got=%0d state=%0d exp=0 state=0", wr_seen, fsm_state); end
  endtask

  task automatic test_random();
    exp_t e;
    logic [15:0] w, e0, e1;
    int lat;
    for (int i = 0; i < 60; i++) begin
      w  = 16'($urandom_range(0, 65535));
      e0 = 16'($urandom_range(0, 65535));
      e1 = 16'($urandom_range(0, 65535));
      lat = int'($urandom_range(0, 3));
      {flag_z, flag_c, flag_n, flag_v} = 4'($urandom_range(0, 15));
      e = model(w, flag_z, flag_c, flag_n, flag_v, lat);
      run_instr(w, e0, e1, lat);
      checks++; if (o_lat !== e.lat || o_pcinc !== e.pcinc) begin failures++; $display("FAIL rnd_seq i=%0d w=%h got=lat%0d pc%0d exp=lat%0d pc%0d", i, w, o_lat, o_pcinc, e.lat, e.pcinc); end
      checks++; if (o_wr !== e.wr || o_br !== e.br || o_ill !== e.ill || o_off !== e.off) begin failures++; $display("FAIL rnd_ctl i=%0d w=%h got=wr%0d br%0d ill%0d off%0d exp=wr%0d br%0d ill%0d off%0d", i, w, o_wr, o_br, o_ill, o_off, e.wr, e.br, e.ill, e.off); end
      checks++; if (o_nhs !== e.next || o_extc !== e.extc) begin failures++; $display("FAIL rnd_ext i=%0d w=%h got=%0d/%0d exp=%0d/%0d", i, w, o_nhs, o_extc, e.next, e.extc); end
      if (e.lat == 4 + e.extc && w[15:14] != 2'b00) begin
        checks++; if (o_op !== e.op || o_src !== e.src || o_dst !== e.dst || o_bop !== e.bop || o_wreg !== e.dst) begin failures++; $display("FAIL rnd_fields i=%0d w=%h got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d", i, w, o_op, o_src, o_dst, o_bop, o_wreg, e.op, e.src, e.dst, e.bop, e.dst); end
        if (e.next > 0) begin
          checks++; if (ext_w[0] !== e0 || int'(ext_s[0]) !== e.sel0) begin failures++; $display("FAIL rnd_ext0 i=%0d w=%h got=%h %b exp=%h %0d", i, w, ext_w[0], ext_s[0], e0, e.sel0); end
        end
        if (e.next > 1) begin
          checks++; if (ext_w[1] !== e1 || int'(ext_s[1]) !== e.sel1) begin failures++; $display("FAIL rnd_ext1 i=%0d w=%h got=%h %b exp=%h %0d", i, w, ext_w[1], ext_s[1], e1, e.sel1); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_watchdog();
    test_add();
    test_jump();
    test_ext_imm();
    test_ext_two();
    test_cmp();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
